// File: rtl/sysarr_mac_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sysarr_mac_pe                                                |
// | Description : Systolic-array MAC processing element with a double-buffered|
// |               stationary weight, a multi-cycle multiply/add pipeline and a |
// |               right-neighbour pass-through. Define MAC_SATURATE_EN to clamp|
// |               the result instead of wrapping it.                           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sysarr_mac_pe #(
  parameter int DW      = 16,
  parameter int MUL_LEN = 2,
  parameter int ADD_LEN = 3
) (
  input  logic                                 clk,
  input  logic                                 nRST,
  input  logic                                 start,
  input  logic                                 MAC_shift,
  input  logic                                 weight_en,
  input  logic                                 weight_swap,
  input  logic [DW-1:0]                        in_value,
  input  logic [DW-1:0]                        in_accumulate,
  output logic [DW-1:0]                        in_pass,
  output logic [DW-1:0]                        out_accumulate,
  output logic                                 value_ready,
  output logic                                 out_valid,
  output logic [$clog2(MUL_LEN+ADD_LEN):0]     count
);

  localparam int CW = $clog2(MUL_LEN + ADD_LEN) + 1;
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;

  localparam logic [CW-1:0] c_one     = CW'(1);
  localparam logic [CW-1:0] c_mul_end = CW'(MUL_LEN);
  localparam logic [CW-1:0] c_all_end = CW'(MUL_LEN + ADD_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_accept;
  logic          w_done;
  logic          w_commit;
  logic          w_pend_nxt;

  logic [DW-1:0] r_pass;
  logic [DW-1:0] r_shadow;
  logic [DW-1:0] r_active;
  logic          r_pend;
  logic [DW-1:0] r_op_val;
  logic [DW-1:0] r_op_acc;
  logic [DW-1:0] r_op_wgt;
  logic [PW-1:0] r_prod;
  logic [DW-1:0] r_result;
  logic          r_valid;
  logic          r_ready;

  logic signed [PW-1:0] w_prod;
  logic signed [SW-1:0] w_sum;
  logic        [DW-1:0] w_result;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MUL;
          w_count_nxt = c_one;
        end
      end
      S_MUL: begin
        w_count_nxt = r_count + c_one;
        if (r_count == c_mul_end) begin
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        if (r_count == c_all_end) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + c_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // A swap requested while busy is parked until the completion edge.
  always_comb begin
    w_commit   = ((r_state == S_IDLE) && weight_swap) ||
                 (w_done && (r_pend || weight_swap));
    w_pend_nxt = r_pend;
    if (w_done) begin
      w_pend_nxt = 1'b0;
    end else if ((r_state != S_IDLE) && weight_swap) begin
      w_pend_nxt = 1'b1;
    end
  end

  assign w_prod = $signed(r_op_wgt) * $signed(r_op_val);
  assign w_sum  = $signed({r_prod[PW-1], r_prod}) +
                  $signed({{(SW-DW){r_op_acc[DW-1]}}, r_op_acc});

`ifdef MAC_SATURATE_EN
  localparam logic signed [SW-1:0] c_sum_max = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] c_sum_min = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    w_result = w_sum[DW-1:0];
    if (w_sum > c_sum_max) begin
      w_result = c_sum_max[DW-1:0];
    end else if (w_sum < c_sum_min) begin
      w_result = c_sum_min[DW-1:0];
    end
  end
`else
  logic w_unused_sum_hi;
  assign w_unused_sum_hi = ^w_sum[SW-1:DW];

  always_comb begin
    w_result = w_sum[DW-1:0];
  end
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_pass   <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
      r_op_val <= '0;
      r_op_acc <= '0;
      r_op_wgt <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      r_valid <= w_done;
      r_ready <= (w_state_nxt == S_IDLE);
      if (MAC_shift) begin
        r_pass <= in_value;
        if (weight_en) begin
          r_shadow <= in_value;
        end
      end
      // Operands are frozen at acceptance so later shifts cannot disturb them.
      if (w_accept) begin
        r_op_val <= in_value;
        r_op_acc <= in_accumulate;
        r_op_wgt <= r_active;
      end
      if (w_commit) begin
        r_active <= r_shadow;
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod;
      end
      if (w_done) begin
        r_result <= w_result;
      end
    end
  end

  assign in_pass        = r_pass;
  assign out_accumulate = r_result;
  assign out_valid      = r_valid;
  assign value_ready    = r_ready;
  assign count          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sysarr_mac_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sysarr_mac_pe                                             |
// | Description : Directed self-checking bench for sysarr_mac_pe.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_sysarr_mac_pe;

  localparam int DW = 16;

  logic          clk;
  logic          nRST;
  logic          start;
  logic          MAC_shift;
  logic          weight_en;
  logic          weight_swap;
  logic [DW-1:0] in_value;
  logic [DW-1:0] in_accumulate;
  logic [DW-1:0] in_pass;
  logic [DW-1:0] out_accumulate;
  logic          value_ready;
  logic          out_valid;
  logic [3:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  sysarr_mac_pe #(.DW(DW), .MUL_LEN(2), .ADD_LEN(3)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .start          (start),
    .MAC_shift      (MAC_shift),
    .weight_en      (weight_en),
    .weight_swap    (weight_swap),
    .in_value       (in_value),
    .in_accumulate  (in_accumulate),
    .in_pass        (in_pass),
    .out_accumulate (out_accumulate),
    .value_ready    (value_ready),
    .out_valid      (out_valid),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_weight(input logic [DW-1:0] w);
    MAC_shift = 1'b1; weight_en = 1'b1; in_value = w;
    step();
    MAC_shift = 1'b0; weight_en = 1'b0; weight_swap = 1'b1;
    step();
    weight_swap = 1'b0;
  endtask

  // Full operation issued now; checks timing and result at start+5.
  task automatic run_op(input string tag, input logic [DW-1:0] v,
                        input logic [DW-1:0] a, input logic [DW-1:0] exp);
    in_value = v; in_accumulate = a; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_count1"}, 32'(count), 32'd1);
    chk({tag, "_busy"}, 32'(value_ready), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk({tag, "_count"}, 32'(count), 32'(k));
      chk({tag, "_novalid"}, 32'(out_valid), 32'd0);
    end
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(out_accumulate), 32'(exp));
    chk({tag, "_ready"}, 32'(value_ready), 32'd1);
    chk({tag, "_count0"}, 32'(count), 32'd0);
  endtask

  logic [DW-1:0] exp_ovf_pos;
  logic [DW-1:0] exp_ovf_neg;
  int            pulses;

  initial begin
`ifdef MAC_SATURATE_EN
    exp_ovf_pos = 16'h7FFF;
    exp_ovf_neg = 16'h8000;
`else
    exp_ovf_pos = 16'h7FFD;
    exp_ovf_neg = 16'h7FFF;
`endif
    nRST = 1'b0; start = 1'b0; MAC_shift = 1'b0; weight_en = 1'b0;
    weight_swap = 1'b0; in_value = '0; in_accumulate = '0;
    #12;
    chk("rst_ready", 32'(value_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_acc", 32'(out_accumulate), 32'd0);
    chk("rst_pass", 32'(in_pass), 32'd0);
    step();
    nRST = 1'b1;
    step();

    // Weight commit and basic op: 3*4+10
    load_weight(16'd3);
    chk("wload_pass", 32'(in_pass), 32'd3);
    run_op("basic", 16'd4, 16'd10, 16'd22);
    step();
    chk("basic_pulse_end", 32'(out_valid), 32'd0);
    chk("basic_hold", 32'(out_accumulate), 32'd22);

    // Deferred swap: shadow=-2 and swap at count=2; result still uses 3
    in_value = 16'd1; in_accumulate = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("defer_count2", 32'(count), 32'd2);
    MAC_shift = 1'b1; weight_en = 1'b1; weight_swap = 1'b1; in_value = 16'hFFFE;
    step();
    MAC_shift = 1'b0; weight_en = 1'b0; weight_swap = 1'b0; in_value = 16'd9;
    step();
    step();
    step();
    chk("defer_valid", 32'(out_valid), 32'd1);
    chk("defer_old_wgt", 32'(out_accumulate), 32'd3);
    run_op("defer_new_wgt", 16'd5, 16'd0, 16'hFFF6);

    // Start while busy at count=3: ignored, operands of first start kept
    in_value = 16'd2; in_accumulate = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("busy_count3", 32'(count), 32'd3);
    start = 1'b1; in_value = 16'd7; in_accumulate = 16'd100;
    step();
    start = 1'b0;
    chk("busy_nv4", 32'(out_valid), 32'd0);
    step();
    chk("busy_nv5", 32'(out_valid), 32'd0);
    step();
    chk("busy_valid", 32'(out_valid), 32'd1);
    chk("busy_result", 32'(out_accumulate), 32'hFFFD);
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    chk("busy_no_second", 32'(pulses), 32'd0);
    chk("busy_idle", 32'(value_ready), 32'd1);

    // Overflow / saturation
    load_weight(16'h7FFF);
    run_op("ovf_pos", 16'd2, 16'h7FFF, exp_ovf_pos);
    load_weight(16'h8000);
    run_op("ovf_neg", 16'd2, 16'h7FFF, exp_ovf_neg);

    // Reset mid-operation at count=2
    in_value = 16'd3; in_accumulate = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mrst_count2", 32'(count), 32'd2);
    #2;
    nRST = 1'b0;
    #1;
    chk("mrst_ready", 32'(value_ready), 32'd1);
    chk("mrst_acc", 32'(out_accumulate), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    chk("mrst_no_valid", 32'(pulses), 32'd0);

    // Weights were cleared by reset: swap zero shadow in, result = accumulate
    weight_swap = 1'b1;
    step();
    weight_swap = 1'b0;
    run_op("post_rst", 16'd5, 16'd9, 16'd9);

    // Pass-through
    MAC_shift = 1'b1; in_value = 16'h1234;
    step();
    MAC_shift = 1'b0; in_value = 16'hABCD;
    chk("pass_latency", 32'(in_pass), 32'h1234);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pass_hold", 32'(in_pass), 32'h1234);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
